// File: rtl/stack_ctl.sv
// stack_ctl: command sequencer that drives a hardware LIFO stack.
//
// Takes stack commands over a valid/ready handshake. Each command becomes
// one-cycle push/pop/swap strobes plus a data word for the stack, and the
// stack's top two entries are read back on i_s0/i_s1. The stack does not
// know its own fill level, so the logical depth is tracked here. Commands
// that would overflow or underflow are rejected and raise sticky flags.
// DROP n and CLEAR are expanded into back-to-back pop cycles.
//
// Handshake: a command transfers on a rising edge where i_valid && o_ready.
// o_ready is high only in IDLE. i_op/i_n/i_data are sampled on that edge
// and ignored at all other times, even if i_valid stays high.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid, o_ready      command handshake
//   i_op                  0 NOP,1 PUSH,2 DROP,3 DUP,4 OVER,5 SWAP,6 REPL,7 CLEAR
//   i_n                   element count for DROP
//   i_data                operand for PUSH / REPL
//   i_s0, i_s1            stack top / next-on-stack read-back
//   o_data                data word to the stack
//   o_push/o_pop/o_swap   registered one-cycle strobes to the stack
//   o_depth               logical depth, 0..DEPTH (post-command while a strobe is high)
//   o_overflow            sticky: a push-class command hit a full stack
//   o_underflow           sticky: a command lacked elements
//   o_dbg_state           current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN)

module stack_ctl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [CNT_W-1:0] i_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic [WIDTH-1:0] i_s0,
    input  logic [WIDTH-1:0] i_s1,
    output logic [WIDTH-1:0] o_data,
    output logic             o_push,
    output logic             o_pop,
    output logic             o_swap,
    output logic [CNT_W-1:0] o_depth,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_DROP  = 3'd2;
    localparam logic [2:0] OP_DUP   = 3'd3;
    localparam logic [2:0] OP_OVER  = 3'd4;
    localparam logic [2:0] OP_SWAP  = 3'd5;
    localparam logic [2:0] OP_REPL  = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LP_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_TWO   = CNT_W'(2);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_depth;
    logic [WIDTH-1:0] r_data;
    logic             r_push;
    logic             r_pop;
    logic             r_swap;
    logic             r_overflow;
    logic             r_underflow;

    logic w_accept;
    logic w_full;
    logic w_ge1;
    logic w_ge2;

    assign w_accept = i_valid && (r_state == S_IDLE);
    assign w_full   = (r_depth == LP_DEPTH);
    assign w_ge1    = (r_depth != '0);
    assign w_ge2    = (r_depth >= LP_TWO);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_depth     <= '0;
            r_data      <= '0;
            r_push      <= 1'b0;
            r_pop       <= 1'b0;
            r_swap      <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_push <= 1'b0;
                    r_pop  <= 1'b0;
                    r_swap <= 1'b0;
                    if (w_accept) begin
                        // Every command, including rejected ones, costs at least
                        // one non-IDLE cycle; this bubble lets i_s0/i_s1 settle
                        // before the next DUP/OVER can be accepted.
                        r_state <= S_ISSUE;
                        case (i_op)
                            OP_PUSH: begin
                                if (!w_full) begin
                                    r_data  <= i_data;
                                    r_push  <= 1'b1;
                                    r_depth <= r_depth + LP_ONE;
                                end else begin
                                    r_overflow <= 1'b1;
                                end
                            end
                            OP_DUP: begin
                                if (w_full) begin
                                    r_overflow <= 1'b1;
                                end else if (w_ge1) begin
                                    r_data  <= i_s0;
                                    r_push  <= 1'b1;
                                    r_depth <= r_depth + LP_ONE;
                                end else begin
                                    r_underflow <= 1'b1;
                                end
                            end
                            OP_OVER: begin
                                if (w_full) begin
                                    r_overflow <= 1'b1;
                                end else if (w_ge2) begin
                                    r_data  <= i_s1;
                                    r_push  <= 1'b1;
                                    r_depth <= r_depth + LP_ONE;
                                end else begin
                                    r_underflow <= 1'b1;
                                end
                            end
                            OP_SWAP: begin
                                if (w_ge2) r_swap      <= 1'b1;
                                else       r_underflow <= 1'b1;
                            end
                            OP_REPL: begin
                                // Simultaneous push+pop replaces the top entry.
                                if (w_ge1) begin
                                    r_data <= i_data;
                                    r_push <= 1'b1;
                                    r_pop  <= 1'b1;
                                end else begin
                                    r_underflow <= 1'b1;
                                end
                            end
                            OP_DROP: begin
                                if (i_n == '0) begin
                                    r_state <= S_ISSUE;
                                end else if (i_n <= r_depth) begin
                                    // First pop is issued on this edge; DRAIN
                                    // supplies the remaining n-1.
                                    r_cnt   <= i_n;
                                    r_pop   <= 1'b1;
                                    r_depth <= r_depth - LP_ONE;
                                    r_state <= S_DRAIN;
                                end else begin
                                    r_underflow <= 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                if (w_ge1) begin
                                    r_cnt   <= r_depth;
                                    r_pop   <= 1'b1;
                                    r_depth <= r_depth - LP_ONE;
                                    r_state <= S_DRAIN;
                                end
                            end
                            OP_NOP:  r_state <= S_ISSUE;
                            default: r_state <= S_ISSUE;
                        endcase
                    end
                end
                S_ISSUE: begin
                    r_push  <= 1'b0;
                    r_pop   <= 1'b0;
                    r_swap  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    // r_cnt counts pops still being presented, including this one.
                    if (r_cnt == LP_ONE) begin
                        r_pop   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - LP_ONE;
                        r_depth <= r_depth - LP_ONE;
                    end
                end
                default: begin
                    r_push  <= 1'b0;
                    r_pop   <= 1'b0;
                    r_swap  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ready     = (r_state == S_IDLE);
    assign o_data      = r_data;
    assign o_push      = r_push;
    assign o_pop       = r_pop;
    assign o_swap      = r_swap;
    assign o_depth     = r_depth;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_stack_ctl.sv
// Bench for stack_ctl. A small behavioural LIFO sits behind the controller
// and feeds i_s0/i_s1 from the controller's strobes. A queue-based reference
// stack (exp_q) predicts the strobes, data, depth and flags of every command.

module tb_stack_ctl;

    localparam int WIDTH = 8;
    localparam int DEPTH = 12;
    localparam int CNT_W = 4;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_valid = 1'b0;
    logic             o_ready;
    logic [2:0]       i_op = 3'd0;
    logic [CNT_W-1:0] i_n = '0;
    logic [WIDTH-1:0] i_data = '0;
    logic [WIDTH-1:0] i_s0;
    logic [WIDTH-1:0] i_s1;
    logic [WIDTH-1:0] o_data;
    logic             o_push;
    logic             o_pop;
    logic             o_swap;
    logic [CNT_W-1:0] o_depth;
    logic             o_overflow;
    logic             o_underflow;
    logic [1:0]       o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    logic [WIDTH-1:0] exp_q[$];
    logic             ref_ovf = 1'b0;
    logic             ref_unf = 1'b0;

    // clock / reset
    always #5 i_clk = ~i_clk;

    stack_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_n         (i_n),
        .i_data      (i_data),
        .i_s0        (i_s0),
        .i_s1        (i_s1),
        .o_data      (o_data),
        .o_push      (o_push),
        .o_pop       (o_pop),
        .o_swap      (o_swap),
        .o_depth     (o_depth),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_dbg_state (o_dbg_state)
    );

    // behavioural stack consumed by the controller
    logic [WIDTH-1:0] mem [0:15];
    logic [3:0]       sp;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sp <= 4'd0;
        end else if (o_push && o_pop) begin
            if (sp != 4'd0) mem[sp - 4'd1] <= o_data;
        end else if (o_push) begin
            mem[sp] <= o_data;
            sp      <= sp + 4'd1;
        end else if (o_pop) begin
            if (sp != 4'd0) sp <= sp - 4'd1;
        end else if (o_swap) begin
            if (sp >= 4'd2) begin
                mem[sp - 4'd1] <= mem[sp - 4'd2];
                mem[sp - 4'd2] <= mem[sp - 4'd1];
            end
        end
    end

    always_comb begin
        i_s0 = '0;
        i_s1 = '0;
        if (sp >= 4'd1) i_s0 = mem[sp - 4'd1];
        if (sp >= 4'd2) i_s1 = mem[sp - 4'd2];
    end

    task automatic do_reset();
        i_valid = 1'b0;
        i_rst   = 1'b1;
        exp_q.delete();
        ref_ovf = 1'b0;
        ref_unf = 1'b0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
    endtask

    // Drives one command and checks it cycle by cycle against exp_q.
    // hold keeps i_valid high with junk opcodes during all but the last drain cycle.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] n,
                           input logic [7:0] data, input bit hold);
        int waitc = 0;
        int d;
        int k = 0;
        logic ep = 1'b0, epo = 1'b0, es = 1'b0;
        logic [7:0] ed = 8'h00;
        logic [7:0] tmp;
        while (!o_ready && waitc < 50) begin
            @(posedge i_clk); #1;
            waitc++;
        end
        if (!o_ready) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: o_ready=%b after %0d cycles, expected 1", o_ready, waitc);
            return;
        end
        d = exp_q.size();
        case (op)
            3'd1: if (d < DEPTH) begin ep = 1; ed = data; exp_q.push_back(data); end
                  else ref_ovf = 1;
            3'd3: if (d == DEPTH) ref_ovf = 1;
                  else if (d >= 1) begin ep = 1; ed = exp_q[d-1]; exp_q.push_back(ed); end
                  else ref_unf = 1;
            3'd4: if (d == DEPTH) ref_ovf = 1;
                  else if (d >= 2) begin ep = 1; ed = exp_q[d-2]; exp_q.push_back(ed); end
                  else ref_unf = 1;
            3'd5: if (d >= 2) begin
                      es = 1; tmp = exp_q[d-1]; exp_q[d-1] = exp_q[d-2]; exp_q[d-2] = tmp;
                  end else ref_unf = 1;
            3'd6: if (d >= 1) begin ep = 1; epo = 1; ed = data; exp_q[d-1] = data; end
                  else ref_unf = 1;
            3'd2: if (n != 0) begin
                      if (int'(n) <= d) k = int'(n);
                      else ref_unf = 1;
                  end
            3'd7: k = d;
            default: ;
        endcase

        i_op = op; i_n = n; i_data = data; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;

        if (k == 0) begin
            n_cmp++;
            if ({o_push, o_pop, o_swap, o_ready} !== {ep, epo, es, 1'b0}) begin
                n_err++;
                $display("FAIL issue_strobes op%0d: push/pop/swap/ready=%b expected %b",
                         op, {o_push, o_pop, o_swap, o_ready}, {ep, epo, es, 1'b0});
            end
            if (ep) begin
                n_cmp++;
                if (o_data !== ed) begin
                    n_err++;
                    $display("FAIL issue_data op%0d: o_data=%h expected %h", op, o_data, ed);
                end
            end
            n_cmp++;
            if (o_depth !== 4'(exp_q.size())) begin
                n_err++;
                $display("FAIL issue_depth op%0d: o_depth=%0d expected %0d", op, o_depth, exp_q.size());
            end
            @(posedge i_clk); #1;
        end else begin
            for (int i = 0; i < k; i++) begin
                n_cmp++;
                if ({o_push, o_pop, o_swap, o_ready} !== 4'b0100) begin
                    n_err++;
                    $display("FAIL drain_strobes cycle%0d: push/pop/swap/ready=%b expected 0100",
                             i, {o_push, o_pop, o_swap, o_ready});
                end
                n_cmp++;
                if (o_depth !== 4'(d - 1 - i)) begin
                    n_err++;
                    $display("FAIL drain_depth cycle%0d: o_depth=%0d expected %0d", i, o_depth, d - 1 - i);
                end
                if (hold && i < k - 1) begin
                    i_valid = 1'b1;
                    i_op    = 3'($urandom_range(1, 7));
                    i_n     = 4'($urandom_range(0, 15));
                end else begin
                    i_valid = 1'b0;
                end
                @(posedge i_clk); #1;
            end
            i_valid = 1'b0;
            repeat (k) void'(exp_q.pop_back());
        end

        n_cmp++;
        if ({o_push, o_pop, o_swap, o_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL back_to_idle op%0d: push/pop/swap/ready=%b expected 0001",
                     op, {o_push, o_pop, o_swap, o_ready});
        end
        n_cmp++;
        if ({o_depth, o_overflow, o_underflow} !== {4'(exp_q.size()), ref_ovf, ref_unf}) begin
            n_err++;
            $display("FAIL depth_flags op%0d: depth=%0d ovf=%b unf=%b expected %0d %b %b",
                     op, o_depth, o_overflow, o_underflow, exp_q.size(), ref_ovf, ref_unf);
        end
        if (exp_q.size() >= 1) begin
            n_cmp++;
            if (i_s0 !== exp_q[exp_q.size()-1]) begin
                n_err++;
                $display("FAIL stack_top op%0d: s0=%h expected %h", op, i_s0, exp_q[exp_q.size()-1]);
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        #12;
        n_cmp++;
        if ({o_push, o_pop, o_swap, o_overflow, o_underflow, o_depth, o_data} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_values: strobes/flags/depth/data=%h expected 0",
                     {o_push, o_pop, o_swap, o_overflow, o_underflow, o_depth, o_data});
        end
        n_cmp++;
        if ({o_ready, o_dbg_state} !== 3'b100) begin
            n_err++;
            $display("FAIL reset_state: ready/state=%b expected 100", {o_ready, o_dbg_state});
        end
        do_reset();
    endtask

    task automatic test_push();
        run_cmd(3'd1, 4'd0, 8'h11, 1'b0);
        run_cmd(3'd1, 4'd0, 8'h22, 1'b0);
        run_cmd(3'd1, 4'd0, 8'h33, 1'b0);
        n_cmp++;
        if ({i_s0, i_s1, o_depth} !== {8'h33, 8'h22, 4'd3}) begin
            n_err++;
            $display("FAIL push_three: s0=%h s1=%h depth=%0d expected 33 22 3", i_s0, i_s1, o_depth);
        end
    endtask

    task automatic test_dup_over_swap();
        run_cmd(3'd3, 4'd0, 8'h00, 1'b0);
        run_cmd(3'd4, 4'd0, 8'h00, 1'b0);
        run_cmd(3'd5, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic test_repl();
        run_cmd(3'd6, 4'd0, 8'h7E, 1'b0);
    endtask

    task automatic test_drop();
        run_cmd(3'd2, 4'd3, 8'h00, 1'b0);
        run_cmd(3'd2, 4'd4, 8'h00, 1'b0);
        run_cmd(3'd2, 4'd0, 8'h00, 1'b0);
        run_cmd(3'd0, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic test_overflow_clear();
        while (exp_q.size() < DEPTH) run_cmd(3'd1, 4'd0, 8'($urandom), 1'b0);
        run_cmd(3'd1, 4'd0, 8'hAA, 1'b0);
        run_cmd(3'd3, 4'd0, 8'h00, 1'b0);
        run_cmd(3'd7, 4'd0, 8'h00, 1'b1);
        run_cmd(3'd7, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid_clear();
        int pops = 0;
        repeat (8) run_cmd(3'd1, 4'd0, 8'($urandom), 1'b0);
        i_op = 3'd7; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (o_pop) pops++;
            @(posedge i_clk); #1;
        end
        if (o_pop) pops++;
        n_cmp++;
        if (pops != 5 || o_depth !== 4'd3) begin
            n_err++;
            $display("FAIL clear_before_reset: pops=%0d depth=%0d expected 5 3", pops, o_depth);
        end
        #2;
        i_rst = 1'b1;
        #1;
        n_cmp++;
        if ({o_pop, o_depth, o_overflow, o_underflow, o_ready} !== 8'b00000001) begin
            n_err++;
            $display("FAIL async_reset: pop/depth/ovf/unf/ready=%b expected 00000001",
                     {o_pop, o_depth, o_overflow, o_underflow, o_ready});
        end
        do_reset();
        run_cmd(3'd3, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 200; t++) begin
            logic [2:0] op;
            int r = $urandom_range(0, 9);
            op = (r < 3) ? 3'd1 : 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
            run_cmd(op, 4'($urandom_range(0, 6)), 8'($urandom), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_push();
        test_dup_over_swap();
        test_repl();
        test_drop();
        test_overflow_clear();
        test_reset_mid_clear();
        do_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
